// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature position counter and its downstream speed meter.
package enc_pkg;

    localparam int          ENC_CNT_W  = 16;
    localparam logic [15:0] CNT_CENTRE = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } enc_state_t;

endpackage

// File: rtl/enc_period_tick.sv
// Free-running window counter 0..PERIOD_CYC-1 with synchronous clear and a tick on the last count.
module enc_period_tick #(
    parameter int PERIOD_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(PERIOD_CYC);

    logic [PW-1:0] cnt_r;

    assign tick = (cnt_r == PW'(PERIOD_CYC - 1));

    // Window counter; wraps to zero on the tick cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + PW'(1);
        end
    end

endmodule

// File: rtl/enc_speed_meter.sv
// Moving-average speed meter: samples the position count once per window and averages the deltas.
module enc_speed_meter
    import enc_pkg::*;
#(
    parameter int CNT_W      = ENC_CNT_W,
    parameter int PERIOD_CYC = 50000,
    parameter int AVG_LOG2   = 2,
    parameter int STOP_WIN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cnt_rst,
    input  logic [CNT_W-1:0] D_in,
    output logic [CNT_W-1:0] speed,
    output logic             speed_vld,
    output logic             dir,
    output logic             stopped
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SW    = CNT_W + AVG_LOG2;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int ZW    = $clog2(STOP_WIN + 1);

    enc_state_t               state_r;
    logic [CNT_W-1:0]         prev_r;
    logic [CNT_W-1:0]         ring_r [DEPTH];
    logic [PW-1:0]            wp_r;
    logic signed [SW-1:0]     sum_r;
    logic [FW-1:0]            fill_r;
    logic [ZW-1:0]            zrun_r;
    logic [CNT_W-1:0]         speed_r;
    logic                     speed_vld_r;
    logic                     dir_r;
    logic                     stopped_r;

    logic                     tick_s;
    logic                     clr_s;
    logic [CNT_W-1:0]         delta_s;
    logic [CNT_W-1:0]         oldest_s;
    logic signed [SW-1:0]     sum_next_s;
    logic [FW-1:0]            fill_next_s;
    logic [ZW-1:0]            zrun_next_s;
    logic [PW-1:0]            wp_next_s;
    logic                     full_s;
    logic [CNT_W-1:0]         speed_next_s;

    assign clr_s = (state_r == IDLE) || !en || cnt_rst;

    enc_period_tick #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Next-window arithmetic: wrapped delta, running sum, fill and zero-run bookkeeping.
    always_comb begin
        delta_s      = D_in - prev_r;
        oldest_s     = ring_r[wp_r];
        sum_next_s   = sum_r + SW'($signed(delta_s)) - SW'($signed(oldest_s));
        speed_next_s = CNT_W'(sum_next_s >>> AVG_LOG2);
        if (fill_r == FW'(DEPTH)) begin
            fill_next_s = fill_r;
        end else begin
            fill_next_s = fill_r + FW'(1);
        end
        full_s = (fill_next_s == FW'(DEPTH));
        if (wp_r == PW'(DEPTH - 1)) begin
            wp_next_s = '0;
        end else begin
            wp_next_s = wp_r + PW'(1);
        end
        if (delta_s != '0) begin
            zrun_next_s = '0;
        end else if (zrun_r == ZW'(STOP_WIN)) begin
            zrun_next_s = zrun_r;
        end else begin
            zrun_next_s = zrun_r + ZW'(1);
        end
    end

    // Measurement FSM and registered outputs; a counter reset restarts the average but keeps the outputs.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_r     <= IDLE;
            prev_r      <= '0;
            for (int i = 0; i < DEPTH; i++) ring_r[i] <= '0;
            wp_r        <= '0;
            sum_r       <= '0;
            fill_r      <= '0;
            zrun_r      <= '0;
            speed_r     <= '0;
            speed_vld_r <= 1'b0;
            stopped_r   <= 1'b0;
            dir_r       <= rst ? 1'b1 : dir_r;
        end else begin
            speed_vld_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= PRIME;
                end
                PRIME, RUN: begin
                    if (cnt_rst) begin
                        state_r <= PRIME;
                        for (int i = 0; i < DEPTH; i++) ring_r[i] <= '0;
                        wp_r    <= '0;
                        sum_r   <= '0;
                        fill_r  <= '0;
                        zrun_r  <= '0;
                    end else if (tick_s) begin
                        prev_r  <= D_in;
                        state_r <= RUN;
                        if (state_r == RUN) begin
                            ring_r[wp_r] <= delta_s;
                            wp_r         <= wp_next_s;
                            sum_r        <= sum_next_s;
                            fill_r       <= fill_next_s;
                            zrun_r       <= zrun_next_s;
                            if (full_s) begin
                                speed_r     <= speed_next_s;
                                speed_vld_r <= 1'b1;
                                stopped_r   <= (zrun_next_s == ZW'(STOP_WIN));
                                if (speed_next_s != '0) begin
                                    dir_r <= ~speed_next_s[CNT_W-1];
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign speed     = speed_r;
    assign speed_vld = speed_vld_r;
    assign dir       = dir_r;
    assign stopped   = stopped_r;

endmodule

// File: tb/tb_enc_speed_meter.sv
// Directed bench for enc_speed_meter with 10-cycle windows, 4-window average and a 2-window stop threshold.
module tb_enc_speed_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cnt_rst;
    logic [15:0] D_in;
    logic [15:0] speed;
    logic        speed_vld;
    logic        dir;
    logic        stopped;

    int checks = 0;
    int errors = 0;

    enc_speed_meter #(
        .CNT_W      (16),
        .PERIOD_CYC (10),
        .AVG_LOG2   (2),
        .STOP_WIN   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cnt_rst   (cnt_rst),
        .D_in      (D_in),
        .speed     (speed),
        .speed_vld (speed_vld),
        .dir       (dir),
        .stopped   (stopped)
    );

    always #5 clk = ~clk;

    // Drop en for one cycle, then raise it; returns 1 time unit after the edge that enters PRIME.
    task automatic restart(input logic [15:0] d0);
        @(negedge clk);
        en   = 1'b0;
        D_in = d0;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Hold D for one window; counts speed_vld pulses seen during it, ending just after the tick edge.
    task automatic window(input logic [15:0] d, output int nv);
        D_in = d;
        nv   = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (speed_vld) nv++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; cnt_rst = 1'b0; D_in = 16'h8000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (speed !== 16'h0000) begin errors++; $display("FAIL reset_speed got %h want %h", speed, 16'h0000); end
        checks++; if (speed_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", speed_vld); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", dir); end
        checks++; if (stopped !== 1'b0) begin errors++; $display("FAIL reset_stopped got %b want 0", stopped); end
        rst = 1'b0;
    endtask

    task automatic test_const_speed;
        int nv;
        restart(16'h8000);
        window(16'h8000, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL const_prime_vld got %0d want 0", nv); end
        for (int k = 1; k <= 3; k++) begin
            window(16'h8000 + 16'(3 * k), nv);
            checks++; if (nv !== 0) begin errors++; $display("FAIL const_fill%0d_vld got %0d want 0", k, nv); end
        end
        window(16'h800C, nv);
        checks++; if (nv !== 1) begin errors++; $display("FAIL const_first_vld got %0d want 1", nv); end
        checks++; if (speed !== 16'd3) begin errors++; $display("FAIL const_speed got %h want %h", speed, 16'd3); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL const_dir got %b want 1", dir); end
        window(16'h800F, nv);
        checks++; if (nv !== 1) begin errors++; $display("FAIL const_next_vld got %0d want 1", nv); end
        checks++; if (speed !== 16'd3) begin errors++; $display("FAIL const_next_speed got %h want %h", speed, 16'd3); end
    endtask

    task automatic test_wrap;
        int nv;
        logic [15:0] d;
        restart(16'hFFF2);
        window(16'hFFF2, nv);
        d = 16'hFFF2;
        for (int k = 0; k < 6; k++) begin
            d = d + 16'd3;
            window(d, nv);
            if (k >= 3) begin
                checks++; if (nv !== 1 || speed !== 16'd3) begin errors++; $display("FAIL wrap_%0d got vld=%0d speed=%h want vld=1 speed=0003", k, nv, speed); end
            end
        end
    endtask

    task automatic test_decel_stop;
        int nv;
        logic [15:0] exp_speed [4] = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'h0000};
        logic        exp_stop  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        restart(16'h8000);
        window(16'h8000, nv);
        window(16'h7FFB, nv);
        window(16'h7FF6, nv);
        window(16'h7FF1, nv);
        window(16'h7FEC, nv);
        checks++; if (speed !== 16'hFFFB) begin errors++; $display("FAIL decel_speed got %h want FFFB", speed); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL decel_dir got %b want 0", dir); end
        for (int k = 0; k < 4; k++) begin
            window(16'h7FEC, nv);
            checks++; if (speed !== exp_speed[k] || nv !== 1) begin errors++; $display("FAIL decay%0d_speed got %h vld=%0d want %h vld=1", k, speed, nv, exp_speed[k]); end
            checks++; if (stopped !== exp_stop[k]) begin errors++; $display("FAIL decay%0d_stopped got %b want %b", k, stopped, exp_stop[k]); end
        end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL decay_dir_hold got %b want 0", dir); end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (stopped !== 1'b0 || speed !== 16'h0000 || dir !== 1'b0) begin errors++; $display("FAIL en_off_stop got stopped=%b speed=%h dir=%b want 0 0000 0", stopped, speed, dir); end
    endtask

    task automatic test_rounding;
        int nv;
        restart(16'h8000);
        window(16'h8000, nv);
        window(16'h8001, nv);
        window(16'h8002, nv);
        window(16'h8003, nv);
        window(16'h8005, nv);
        checks++; if (speed !== 16'd1 || dir !== 1'b1) begin errors++; $display("FAIL round_pos got speed=%h dir=%b want 0001 1", speed, dir); end
        restart(16'h8000);
        window(16'h8000, nv);
        window(16'h7FFF, nv);
        window(16'h7FFE, nv);
        window(16'h7FFD, nv);
        window(16'h7FFB, nv);
        checks++; if (speed !== 16'hFFFE || dir !== 1'b0) begin errors++; $display("FAIL round_neg got speed=%h dir=%b want FFFE 0", speed, dir); end
    endtask

    task automatic test_cnt_rst;
        int nv;
        restart(16'h8000);
        window(16'h8000, nv);
        window(16'h8003, nv);
        window(16'h8006, nv);
        window(16'h8009, nv);
        window(16'h800C, nv);
        repeat (3) @(posedge clk);
        #1;
        cnt_rst = 1'b1;
        D_in    = 16'h8000;
        @(posedge clk);
        #1;
        cnt_rst = 1'b0;
        checks++; if (speed !== 16'd3 || speed_vld !== 1'b0) begin errors++; $display("FAIL cntrst_hold got speed=%h vld=%b want 0003 0", speed, speed_vld); end
        window(16'h8000, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL cntrst_prime_vld got %0d want 0", nv); end
        for (int k = 1; k <= 3; k++) begin
            window(16'h8000 + 16'(2 * k), nv);
            checks++; if (nv !== 0 || speed !== 16'd3) begin errors++; $display("FAIL cntrst_fill%0d got vld=%0d speed=%h want 0 0003", k, nv, speed); end
        end
        window(16'h8008, nv);
        checks++; if (nv !== 1 || speed !== 16'd2) begin errors++; $display("FAIL cntrst_resume got vld=%0d speed=%h want 1 0002", nv, speed); end
        repeat (9) @(posedge clk);
        #1;
        cnt_rst = 1'b1;
        D_in    = 16'h8000;
        @(posedge clk);
        #1;
        cnt_rst = 1'b0;
        checks++; if (speed_vld !== 1'b0 || speed !== 16'd2) begin errors++; $display("FAIL cntrst_tick got vld=%b speed=%h want 0 0002", speed_vld, speed); end
        window(16'h8000, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL cntrst_tick_prime got %0d want 0", nv); end
    endtask

    task automatic test_rst_en_mid_run;
        int nv;
        restart(16'h8000);
        window(16'h8000, nv);
        window(16'h7FFB, nv);
        window(16'h7FF6, nv);
        window(16'h7FF1, nv);
        window(16'h7FEC, nv);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (speed !== 16'h0000 || speed_vld !== 1'b0 || stopped !== 1'b0 || dir !== 1'b0) begin errors++; $display("FAIL en_off got speed=%h vld=%b stop=%b dir=%b want 0000 0 0 0", speed, speed_vld, stopped, dir); end
        restart(16'h8000);
        window(16'h8000, nv);
        window(16'h7FFB, nv);
        window(16'h7FF6, nv);
        window(16'h7FF1, nv);
        window(16'h7FEC, nv);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (speed !== 16'h0000 || speed_vld !== 1'b0 || stopped !== 1'b0 || dir !== 1'b1) begin errors++; $display("FAIL rst_mid got speed=%h vld=%b stop=%b dir=%b want 0000 0 0 1", speed, speed_vld, stopped, dir); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        window(16'h8000, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL rst_prime_vld got %0d want 0", nv); end
        window(16'h8007, nv);
        window(16'h800E, nv);
        window(16'h8015, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL rst_fill_vld got %0d want 0", nv); end
        window(16'h801C, nv);
        checks++; if (nv !== 1 || speed !== 16'd7 || dir !== 1'b1) begin errors++; $display("FAIL rst_restart got vld=%0d speed=%h dir=%b want 1 0007 1", nv, speed, dir); end
    endtask

    initial begin
        test_reset;
        test_const_speed;
        test_wrap;
        test_decel_stop;
        test_rounding;
        test_cnt_rst;
        test_rst_en_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
